// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bundle between the fetch unit and its memory.
// Handshake: imem_req is held high with imem_addr stable until a cycle with imem_ack=1;
// imem_rdata is valid only in that ack cycle, and the ack may land in the same cycle req rises.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, IF/ID pipeline register, stall hold buffer and
// squashing of in-flight fetches when the decode stage redirects to a branch or jump target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_unit_if.master         imem,
  input  logic                 stall,
  input  logic                 branch,
  input  logic [31:0]          branch_target,
  input  logic                 jumpsel,
  input  logic [31:0]          jump_target,
  output logic [31:0]          ifid_instr,
  output logic [31:0]          ifid_pc4,
  output logic                 ifid_valid,
  output logic [5:0]           opc,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] buf_instr, buf_instr_n;
  logic [31:0] buf_pc4, buf_pc4_n;
  logic [31:0] req_addr, req_addr_n;
  logic [31:0] ifid_instr_n, ifid_pc4_n;
  logic        ifid_valid_n;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // A stalled decode stage cannot commit a redirect, so it is ignored outright.
  assign redirect = (branch | jumpsel) & ~stall;
  assign target   = branch ? branch_target : jump_target;
  assign pc_plus4 = pc + 32'd4;

  assign imem.imem_req  = (state != HOLD);
  assign imem.imem_addr = (state == DISCARD) ? req_addr : pc;
  assign opc            = ifid_instr[31:26];
  assign state_dbg      = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      buf_instr  <= 32'h0;
      buf_pc4    <= 32'h0;
      req_addr   <= 32'h0;
      ifid_instr <= 32'h0;
      ifid_pc4   <= 32'h0;
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      buf_instr  <= buf_instr_n;
      buf_pc4    <= buf_pc4_n;
      req_addr   <= req_addr_n;
      ifid_instr <= ifid_instr_n;
      ifid_pc4   <= ifid_pc4_n;
      ifid_valid <= ifid_valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    buf_instr_n  = buf_instr;
    buf_pc4_n    = buf_pc4;
    req_addr_n   = req_addr;
    ifid_instr_n = ifid_instr;
    ifid_pc4_n   = ifid_pc4;
    ifid_valid_n = ifid_valid;

    case (state)
      FETCH: begin
        if (redirect) begin
          pc_n         = target;
          ifid_instr_n = 32'h0;
          ifid_valid_n = 1'b0;
          // Without an ack the old request is still owed a response; park its address.
          if (!imem.imem_ack) begin
            req_addr_n = pc;
            state_n    = DISCARD;
          end
        end else if (imem.imem_ack && !stall) begin
          ifid_instr_n = imem.imem_rdata;
          ifid_pc4_n   = pc_plus4;
          ifid_valid_n = 1'b1;
          pc_n         = pc_plus4;
        end else if (imem.imem_ack && stall) begin
          buf_instr_n = imem.imem_rdata;
          buf_pc4_n   = pc_plus4;
          pc_n        = pc_plus4;
          state_n     = HOLD;
        end else if (!stall) begin
          ifid_instr_n = 32'h0;
          ifid_valid_n = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_n         = target;
          ifid_instr_n = 32'h0;
          ifid_valid_n = 1'b0;
          state_n      = FETCH;
        end else if (!stall) begin
          ifid_instr_n = buf_instr;
          ifid_pc4_n   = buf_pc4;
          ifid_valid_n = 1'b1;
          state_n      = FETCH;
        end
      end

      DISCARD: begin
        if (!stall) begin
          ifid_instr_n = 32'h0;
          ifid_valid_n = 1'b0;
        end
        if (redirect) begin
          pc_n = target;
        end
        if (imem.imem_ack) begin
          state_n = FETCH;
        end
      end

      default: begin
        state_n = FETCH;
      end
    endcase
  end

endmodule
